// File: rtl/mul_8bit_seq_pkg.sv
// Shared arithmetic definitions for the sequential multiplier slice.
package mul_8bit_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_STEPS = 8;

endpackage

// File: rtl/full_adder_8bit.sv
// 8-bit combinational adder with carry-in and carry-out; the multiplier's only arithmetic resource.
module full_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // Nine-bit add so the carry-out falls out of the top bit.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
  end

endmodule

// File: rtl/mul_8bit_seq.sv
// Unsigned 8x8 -> 16 shift-and-add multiplier, one add-shift step per cycle through a shared 8-bit adder.
module mul_8bit_seq
  import mul_8bit_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        ready,
  output logic        done,
  output logic [15:0] product
);

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] mcand;
  logic [7:0] hi;
  logic [7:0] lo;

  logic [7:0] addend;
  logic [7:0] sum;
  logic       cout;

  // The multiplicand only contributes when the current multiplier bit (lo[0]) is set.
  always_comb begin
    addend = lo[0] ? mcand : 8'd0;
  end

  full_adder_8bit u_adder (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Control FSM and accumulator; ready/done are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      mcand <= 8'd0;
      hi    <= 8'd0;
      lo    <= 8'd0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= 8'd0;
            cnt   <= 3'd0;
            state <= RUN;
            ready <= 1'b0;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        RUN: begin
          {hi, lo} <= {cout, sum, lo[7:1]};
          cnt      <= cnt + 3'd1;
          if (cnt == 3'(MUL_STEPS - 1)) begin
            state <= DONE;
            ready <= 1'b1;
            done  <= 1'b1;
          end else begin
            ready <= 1'b0;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // The accumulator itself is the product; it only moves during RUN or on an accepted start.
  always_comb begin
    product = {hi, lo};
  end

endmodule

// File: tb/tb_mul_8bit_seq.sv
// Self-checking bench for mul_8bit_seq: directed vectors, back-to-back and reset corner cases, random sweep.
module tb_mul_8bit_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        done;
  logic [15:0] product;

  int checks;
  int errors;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[7];

  mul_8bit_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one start pulse, then counts negedges until done (bounded), tracking ready-low cycles.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                               output logic [15:0] res, output int lat, output int low_cnt);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    low_cnt = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (!ready) low_cnt++;
      if (done) break;
    end
    res = product;
  endtask

  // Waits for done with a bound; start/a/b are left as the caller set them.
  task automatic waitDone(output int lat);
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
  endtask

  initial begin
    logic [15:0] res;
    logic [15:0] held;
    logic [15:0] expected;
    logic [7:0]  x;
    logic [7:0]  y;
    int          lat;
    int          low_cnt;
    int          done_seen;
    int          gap;
    int          stable_bad;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = 8'd0;
    b      = 8'd0;

    vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hFF, 16'h0000};
    vecs[3] = '{8'hA5, 8'h00, 16'h0000};
    vecs[4] = '{8'h03, 8'h05, 16'h000F};
    vecs[5] = '{8'h80, 8'h02, 16'h0100};
    vecs[6] = '{8'h12, 8'h34, 16'h03A8};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_product", 32'(product), 32'h0);

    // Directed vectors: product, latency, ready-low duration, single-cycle done, output hold.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, res, lat, low_cnt);
      checkOutput($sformatf("vec%0d_product", i), 32'(res), 32'(vecs[i].p));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      checkOutput($sformatf("vec%0d_ready_low", i), 32'(low_cnt), 32'd8);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      checkOutput($sformatf("vec%0d_hold", i), 32'(product), 32'(vecs[i].p));
    end

    // Back-to-back: start held high, operands change mid-run, restart accepted in the done cycle.
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h80;
    b = 8'h02;
    waitDone(lat);
    checkOutput("b2b_first_product", 32'(product), 32'h03A8);
    checkOutput("b2b_first_latency", 32'(lat), 32'd9);
    waitDone(lat);
    start = 1'b0;
    checkOutput("b2b_second_product", 32'(product), 32'h0100);
    checkOutput("b2b_second_latency", 32'(lat), 32'd9);
    @(negedge clk);
    checkOutput("b2b_idle_done", 32'(done), 32'd0);

    // Reset mid-run discards the operation.
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_ready", 32'(ready), 32'd1);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_product", 32'(product), 32'h0);
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("midrst_no_done", 32'(done_seen), 32'd0);
    applyStimulus(8'h03, 8'h05, res, lat, low_cnt);
    checkOutput("midrst_next_product", 32'(res), 32'h000F);
    checkOutput("midrst_next_latency", 32'(lat), 32'd9);

    // Random sweep against plain multiplication; product must hold through a random idle gap.
    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      expected = 16'(x) * 16'(y);
      applyStimulus(x, y, res, lat, low_cnt);
      checkOutput($sformatf("rnd%0d_product", n), 32'(res), 32'(expected));
      checkOutput($sformatf("rnd%0d_latency", n), 32'(lat), 32'd9);
      held = res;
      gap = $urandom_range(0, 3);
      stable_bad = 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (product !== held) stable_bad++;
      end
      checkOutput($sformatf("rnd%0d_hold", n), 32'(stable_bad), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
